gpr_write_scheduler: RTL and testbench

//  Owns the single GPR write port (pos3/WriteEnable/WData/pc) and shares it between the

---
 rtl/gpr_write_scheduler_pkg.sv | 24 ++
 rtl/gpr_write_scheduler_md_result_fifo.sv | 65 ++++++
 rtl/gpr_write_scheduler.sv | 158 +++++++++++++++
 tb/tb_gpr_write_scheduler.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_write_scheduler_pkg.sv
// Shared types for the GPR write-port scheduler: register/data widths and the write request record.
package gpr_write_scheduler_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam int NREG   = 32;

    typedef struct packed {
        logic [REG_W-1:0]  addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] pc;
    } wr_req_t;

    // One-hot register select; register 0 never maps to a bit so it can never become busy.
    function automatic logic [NREG-1:0] reg_onehot(input logic [REG_W-1:0] a);
        logic [NREG-1:0] v;
        v = {NREG{1'b0}};
        if (a != {REG_W{1'b0}}) begin
            v[a] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/gpr_write_scheduler_md_result_fifo.sv
// Small FIFO that buffers multiply/divide results until the GPR write port is granted to them.
module md_result_fifo
    import gpr_write_scheduler_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    i_clk,
    input  logic    i_reset,
    input  logic    i_push,
    input  wr_req_t i_push_data,
    input  logic    i_pop,
    output logic    o_full,
    output logic    o_empty,
    output wr_req_t o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    wr_req_t       r_mem [DEPTH];
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == {CW{1'b0}});
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Pointer and occupancy tracking; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/gpr_write_scheduler.sv
// Shares the single GPR write port between writeback and buffered MD results, with an
// anti-starvation age counter and a busy scoreboard that stalls decode on pending MD destinations.
module gpr_write_scheduler
    import gpr_write_scheduler_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wb_valid,
    input  logic [REG_W-1:0]  i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic [DATA_W-1:0] i_wb_pc,
    input  logic              i_md_valid,
    output logic              o_md_ready,
    input  logic [REG_W-1:0]  i_md_addr,
    input  logic [DATA_W-1:0] i_md_data,
    input  logic [DATA_W-1:0] i_md_pc,
    input  logic              i_rsv_valid,
    input  logic [REG_W-1:0]  i_rsv_addr,
    input  logic [REG_W-1:0]  i_id_rs,
    input  logic [REG_W-1:0]  i_id_rt,
    input  logic [REG_W-1:0]  i_id_rd,
    output logic              o_stall,
    output logic              o_wb_stall,
    output logic              o_gpr_we,
    output logic [REG_W-1:0]  o_gpr_waddr,
    output logic [DATA_W-1:0] o_gpr_wdata,
    output logic [DATA_W-1:0] o_gpr_pc,
    output logic [NREG-1:0]   o_busy
);

    localparam int AGE_W = $clog2(STARVE_MAX + 1);

    logic              w_push;
    logic              w_pop;
    logic              w_wb_take;
    logic              w_full;
    logic              w_empty;
    logic              w_force;
    logic              w_wb_ok;
    wr_req_t           w_head;
    wr_req_t           w_md_req;
    wr_req_t           w_sel;
    logic [AGE_W-1:0]  w_age_nxt;
    logic [NREG-1:0]   w_busy_nxt;

    logic [AGE_W-1:0]  r_age;
    logic [NREG-1:0]   r_busy;
    logic              r_gpr_we;
    logic [REG_W-1:0]  r_gpr_waddr;
    logic [DATA_W-1:0] r_gpr_wdata;
    logic [DATA_W-1:0] r_gpr_pc;

    assign w_md_req = '{addr: i_md_addr, data: i_md_data, pc: i_md_pc};

    // Results for r0 are acknowledged but dropped, so they never compete for the port.
    assign o_md_ready = ~w_full;
    assign w_push     = i_md_valid & ~w_full & (i_md_addr != {REG_W{1'b0}});
    assign w_wb_ok    = i_wb_valid & (i_wb_addr != {REG_W{1'b0}});
    assign w_force    = ~w_empty & (r_age >= AGE_W'(STARVE_MAX));

    md_result_fifo #(
        .DEPTH (DEPTH)
    ) u_md_fifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_push      (w_push),
        .i_push_data (w_md_req),
        .i_pop       (w_pop),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head      (w_head)
    );

    // Port arbitration: a starved MD head beats WB, otherwise WB beats the buffer.
    always_comb begin
        w_pop     = 1'b0;
        w_wb_take = 1'b0;
        w_sel     = w_head;
        if (w_force) begin
            w_pop = 1'b1;
        end else if (w_wb_ok) begin
            w_wb_take = 1'b1;
            w_sel     = '{addr: i_wb_addr, data: i_wb_data, pc: i_wb_pc};
        end else if (~w_empty) begin
            w_pop = 1'b1;
        end else begin
            w_sel = w_head;
        end
    end

    // Age of the current head; restarts whenever the head leaves or the buffer drains.
    always_comb begin
        w_age_nxt = r_age;
        if (w_empty || w_pop) begin
            w_age_nxt = {AGE_W{1'b0}};
        end else if (r_age < AGE_W'(STARVE_MAX)) begin
            w_age_nxt = r_age + AGE_W'(1);
        end else begin
            w_age_nxt = r_age;
        end
    end

    // Scoreboard update: the clear is applied first so a same-cycle reservation wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_pop) begin
            w_busy_nxt = w_busy_nxt & ~reg_onehot(w_head.addr);
        end else begin
            w_busy_nxt = r_busy;
        end
        if (i_rsv_valid) begin
            w_busy_nxt = w_busy_nxt | reg_onehot(i_rsv_addr);
        end else begin
            w_busy_nxt = w_busy_nxt;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Age and scoreboard state.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_age  <= {AGE_W{1'b0}};
            r_busy <= {NREG{1'b0}};
        end else begin
            r_age  <= w_age_nxt;
            r_busy <= w_busy_nxt;
        end
    end

    // Registered GPR write port; address/data/pc hold their last values when idle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_gpr_we    <= 1'b0;
            r_gpr_waddr <= {REG_W{1'b0}};
            r_gpr_wdata <= {DATA_W{1'b0}};
            r_gpr_pc    <= {DATA_W{1'b0}};
        end else if (w_pop || w_wb_take) begin
            r_gpr_we    <= 1'b1;
            r_gpr_waddr <= w_sel.addr;
            r_gpr_wdata <= w_sel.data;
            r_gpr_pc    <= w_sel.pc;
        end else begin
            r_gpr_we    <= 1'b0;
        end
    end

    assign o_gpr_we    = r_gpr_we;
    assign o_gpr_waddr = r_gpr_waddr;
    assign o_gpr_wdata = r_gpr_wdata;
    assign o_gpr_pc    = r_gpr_pc;
    assign o_busy      = r_busy;
    assign o_wb_stall  = w_force;
    assign o_stall     = r_busy[i_id_rs] | r_busy[i_id_rt] | r_busy[i_id_rd];

endmodule

// File: tb/tb_gpr_write_scheduler.sv
// Directed and randomized bench for gpr_write_scheduler against a queue-based reference model.
module tb_gpr_write_scheduler;

    localparam int DEPTH  = 2;
    localparam int STARVE = 4;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] p;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_valid = 1'b0, md_valid = 1'b0, rsv_valid = 1'b0;
    logic [4:0]  wb_addr = 5'd0, md_addr = 5'd0, rsv_addr = 5'd0;
    logic [4:0]  id_rs = 5'd0, id_rt = 5'd0, id_rd = 5'd0;
    logic [31:0] wb_data = 32'd0, wb_pc = 32'd0, md_data = 32'd0, md_pc = 32'd0;
    logic        md_ready, stall, wb_stall, gpr_we;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata, gpr_pc, busy;

    int          n_checks = 0;
    int          n_errors = 0;

    ent_t        q[$];
    logic [31:0] m_busy;
    int          m_age;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata, m_pc;
    logic        m_accept;
    logic        obs_wb_stall;

    gpr_write_scheduler #(.DEPTH(DEPTH), .STARVE_MAX(STARVE)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_wb_valid(wb_valid), .i_wb_addr(wb_addr), .i_wb_data(wb_data), .i_wb_pc(wb_pc),
        .i_md_valid(md_valid), .o_md_ready(md_ready), .i_md_addr(md_addr),
        .i_md_data(md_data), .i_md_pc(md_pc),
        .i_rsv_valid(rsv_valid), .i_rsv_addr(rsv_addr),
        .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_rd(id_rd),
        .o_stall(stall), .o_wb_stall(wb_stall),
        .o_gpr_we(gpr_we), .o_gpr_waddr(gpr_waddr), .o_gpr_wdata(gpr_wdata),
        .o_gpr_pc(gpr_pc), .o_busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        m_busy  = 32'd0;
        m_age   = 0;
        m_we    = 1'b0;
        m_waddr = 5'd0;
        m_wdata = 32'd0;
        m_pc    = 32'd0;
    endfunction

    // Reference behaviour of one clock edge, using the inputs held across it.
    function automatic void model_edge();
        int   sz;
        bit   force_head;
        bit   popped;
        bit   wb_ok;
        ent_t h;
        sz         = q.size();
        force_head = (sz > 0) && (m_age >= STARVE);
        wb_ok      = wb_valid && (wb_addr != 5'd0);
        popped     = 1'b0;
        if (force_head || (!wb_ok && sz > 0)) begin
            h       = q.pop_front();
            popped  = 1'b1;
            m_we    = 1'b1;
            m_waddr = h.a;
            m_wdata = h.d;
            m_pc    = h.p;
            m_busy[h.a] = 1'b0;
        end else if (wb_ok) begin
            m_we    = 1'b1;
            m_waddr = wb_addr;
            m_wdata = wb_data;
            m_pc    = wb_pc;
        end else begin
            m_we    = 1'b0;
        end
        if (m_accept && md_addr != 5'd0) q.push_back('{md_addr, md_data, md_pc});
        if (rsv_valid && rsv_addr != 5'd0) m_busy[rsv_addr] = 1'b1;
        m_busy[0] = 1'b0;
        if (popped || sz == 0) m_age = 0;
        else if (m_age < STARVE) m_age++;
    endfunction

    task automatic step();
        logic e_stall;
        #1;
        e_stall = m_busy[id_rs] | m_busy[id_rt] | m_busy[id_rd];
        obs_wb_stall = wb_stall;
        check("md_ready", 32'(md_ready), 32'(q.size() < DEPTH));
        check("stall", 32'(stall), 32'(e_stall));
        check("wb_stall", 32'(wb_stall), 32'((q.size() > 0) && (m_age >= STARVE)));
        m_accept = !reset && md_valid && (q.size() < DEPTH);
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        #1;
        check("gpr_we", 32'(gpr_we), 32'(m_we));
        check("gpr_waddr", 32'(gpr_waddr), 32'(m_waddr));
        check("gpr_wdata", gpr_wdata, m_wdata);
        check("gpr_pc", gpr_pc, m_pc);
        check("busy", busy, m_busy);
    endtask

    task automatic idle_inputs();
        wb_valid = 1'b0; md_valid = 1'b0; rsv_valid = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
    endtask

    initial begin
        bit accepted;
        model_reset();
        step();
        step();
        reset = 1'b0;
        step();

        // Plain writeback.
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234; wb_pc = 32'h100;
        step();
        check("t2_we", 32'(gpr_we), 32'd1);
        check("t2_waddr", 32'(gpr_waddr), 32'd5);
        check("t2_wdata", gpr_wdata, 32'h1234);
        idle_inputs();
        step();

        // Reservation, MD write, stall release.
        rsv_valid = 1'b1; rsv_addr = 5'd8;
        step();
        rsv_valid = 1'b0;
        check("t3_busy8", 32'(busy[8]), 32'd1);
        id_rs = 5'd8;
        md_valid = 1'b1; md_addr = 5'd8; md_data = 32'hAA; md_pc = 32'h200;
        step();
        check("t3_stall_held", 32'(stall), 32'd1);
        md_valid = 1'b0;
        step();
        check("t3_waddr", 32'(gpr_waddr), 32'd8);
        check("t3_wdata", gpr_wdata, 32'hAA);
        check("t3_busy8_clr", 32'(busy[8]), 32'd0);
        check("t3_stall_drop", 32'(stall), 32'd0);
        idle_inputs();
        step();

        // Starvation: WB every cycle, buffered r9 forced through on the fifth.
        md_valid = 1'b1; md_addr = 5'd9; md_data = 32'h99; md_pc = 32'h300;
        wb_valid = 1'b1; wb_addr = 5'd10; wb_data = 32'h1; wb_pc = 32'h304;
        step();
        md_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wb_addr = 5'(11 + k); wb_data = 32'(k); wb_pc = 32'h308 + 32'(k);
            step();
            check("t4_wb_stall", 32'(obs_wb_stall), 32'(k == 4));
        end
        check("t4_waddr", 32'(gpr_waddr), 32'd9);
        idle_inputs();
        step();

        // Fill the buffer while WB keeps the port; third result waits for space.
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h33; wb_pc = 32'h400;
        md_valid = 1'b1; md_addr = 5'd11; md_data = 32'hB11;
        step();
        md_addr = 5'd12; md_data = 32'hB12;
        step();
        md_addr = 5'd13; md_data = 32'hB13;
        #0;
        check("t5_full_ready", 32'(md_ready), 32'd0);
        accepted = 1'b0;
        for (int c = 0; c < 20 && !accepted; c++) begin
            step();
            accepted = m_accept;
        end
        check("t5_third_accepted", 32'(accepted), 32'd1);
        idle_inputs();
        for (int c = 0; c < 4; c++) step();

        // Register 0 on both paths.
        wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD;
        md_valid = 1'b1; md_addr = 5'd0; md_data = 32'hBEEF;
        rsv_valid = 1'b1; rsv_addr = 5'd0;
        step();
        check("t6_we", 32'(gpr_we), 32'd0);
        check("t6_busy", busy, 32'd0);
        idle_inputs();
        step();

        // Reset in the middle of traffic with two buffered results and a reservation.
        wb_valid = 1'b1; wb_addr = 5'd4;
        md_valid = 1'b1; md_addr = 5'd20; rsv_valid = 1'b1; rsv_addr = 5'd20;
        step();
        rsv_valid = 1'b0; md_addr = 5'd21;
        step();
        idle_inputs();
        reset = 1'b1;
        #1;
        check("t1_we", 32'(gpr_we), 32'd0);
        check("t1_waddr", 32'(gpr_waddr), 32'd0);
        check("t1_wdata", gpr_wdata, 32'd0);
        check("t1_pc", gpr_pc, 32'd0);
        check("t1_busy", busy, 32'd0);
        model_reset();
        step();
        reset = 1'b0;
        #0;
        check("t1_ready", 32'(md_ready), 32'd1);
        step();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            wb_valid = ($urandom_range(1, 0) == 1);
            wb_addr  = 5'($urandom_range(31, 0));
            wb_data  = $urandom;
            wb_pc    = $urandom;
            if (!md_valid || m_accept) begin
                md_valid = ($urandom_range(4, 0) < 2);
                md_addr  = 5'($urandom_range(31, 0));
                md_data  = $urandom;
                md_pc    = $urandom;
            end
            rsv_addr  = 5'($urandom_range(31, 0));
            rsv_valid = ($urandom_range(4, 0) == 0) && !m_busy[rsv_addr];
            id_rs = 5'($urandom_range(31, 0));
            id_rt = 5'($urandom_range(31, 0));
            id_rd = 5'($urandom_range(31, 0));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
